// File: rtl/accum_feeder_pkg.sv
// Shared types and default sizing for the accumulator feeder.
package accum_feeder_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD1 = 2'd2,
        HOLD2 = 2'd3
    } state_t;

endpackage

// File: rtl/accum_feeder_fifo.sv
// Small circular sample FIFO; head is the oldest entry, valid whenever !empty.
module feeder_fifo
    import accum_feeder_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              do_push;
    logic              do_pop;

    // Occupancy is registered, so a same-cycle pop never frees room for a push while full.
    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/accum_feeder.sv
// Feeds queued samples to a 3-cycle downstream accumulator: one enable strobe,
// then the addend is held for two more cycles before the next sample may issue.
module accum_feeder
    import accum_feeder_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              enable,
    output logic [DATA_W-1:0] value,
    output logic              busy,
    output logic [15:0]       issued_count
);

    state_t            state_reg;
    logic              enable_reg;
    logic [DATA_W-1:0] value_reg;
    logic [15:0]       issued_count_reg;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;

    assign in_ready  = !fifo_full && !RST;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = !RST && !fifo_empty && ((state_reg == IDLE) || (state_reg == HOLD2));

    feeder_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg        <= IDLE;
            enable_reg       <= 1'b0;
            value_reg        <= '0;
            issued_count_reg <= '0;
        end else begin
            enable_reg <= 1'b0;
            case (state_reg)
                IDLE, HOLD2: begin
                    // Popping on the way into ISSUE makes enable and value appear together.
                    if (!fifo_empty) begin
                        value_reg  <= fifo_head;
                        enable_reg <= 1'b1;
                        state_reg  <= ISSUE;
                    end else begin
                        state_reg  <= IDLE;
                    end
                end
                ISSUE: begin
                    issued_count_reg <= issued_count_reg + 16'd1;
                    state_reg        <= HOLD1;
                end
                HOLD1: begin
                    state_reg <= HOLD2;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign enable       = enable_reg;
    assign value        = value_reg;
    assign issued_count = issued_count_reg;
    assign busy         = !fifo_empty || (state_reg != IDLE);

endmodule

// File: tb/tb_accum_feeder.sv
// Self-checking bench for accum_feeder: directed vector table, corner-case sequences,
// and randomized traffic against a cycle-arithmetic reference model.
module tb_accum_feeder;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        enable;
    logic [31:0] value;
    logic        busy;
    logic [15:0] issued_count;

    accum_feeder #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .enable       (enable),
        .value        (value),
        .busy         (busy),
        .issued_count (issued_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        vld;
        logic [31:0] dat;
        logic        e_rdy;
        logic        e_en;
        logic [31:0] e_val;
        logic        e_busy;
    } vec_t;

    vec_t tab[$];
    vec_t tab_row;
    bit   tab_chk = 0;
    int   tab_idx = 0;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: samples waiting in the FIFO, and the cycle of the latest strobe.
    logic [31:0] pend[$];
    int          cyc    = 0;
    int          last_e = -100;
    logic [31:0] m_value = '0;
    logic [15:0] m_count = '0;

    // Downstream accumulator model: adds value two cycles after each strobe.
    logic [1:0]  acc_pipe = '0;
    logic [31:0] acc = '0;

    int n_acc   = 0;
    int n_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void add(input logic v, input logic [31:0] d, input logic rdy,
                                input logic en, input logic [31:0] val, input logic bsy);
        vec_t r;
        r.vld = v; r.dat = d; r.e_rdy = rdy; r.e_en = en; r.e_val = val; r.e_busy = bsy;
        tab.push_back(r);
    endfunction

    task automatic cycle(input logic r, input logic v, input logic [31:0] d);
        logic exp_rdy;
        logic exp_en;
        logic exp_busy;
        RST = r; in_valid = v; in_data = d;
        @(negedge CLK);
        exp_rdy  = !r && (pend.size() < DEPTH);
        exp_en   = (cyc == last_e);
        exp_busy = (pend.size() > 0) || (cyc <= last_e + 2);
        chk("in_ready", in_ready, exp_rdy);
        chk("enable", enable, exp_en);
        chk("value", value, m_value);
        chk("busy", busy, exp_busy);
        chk("issued_count", issued_count, m_count);
        if (tab_chk) begin
            chk($sformatf("tab%0d_ready", tab_idx), in_ready, tab_row.e_rdy);
            chk($sformatf("tab%0d_enable", tab_idx), enable, tab_row.e_en);
            chk($sformatf("tab%0d_value", tab_idx), value, tab_row.e_val);
            chk($sformatf("tab%0d_busy", tab_idx), busy, tab_row.e_busy);
        end
        if (acc_pipe[1]) acc += value;
        acc_pipe = {acc_pipe[0], enable};
        if (in_valid && in_ready) n_acc++;
        if (in_valid && !in_ready) n_stall++;
        if (enable) $display("issue cycle=%0d value=%h count=%0d", cyc, value, issued_count);
        @(posedge CLK);
        if (r) begin
            pend.delete();
            last_e  = -100;
            m_value = '0;
            m_count = '0;
        end else begin
            if (cyc == last_e) m_count++;
            if ((pend.size() > 0) && (cyc >= last_e + 2)) begin
                m_value = pend.pop_front();
                last_e  = cyc + 1;
            end
            if (v && exp_rdy) pend.push_back(d);
        end
        cyc++;
        #1;
    endtask

    initial begin
        // Single sample of 5
        add(1, 32'h5, 1, 0, 32'h0, 0);
        add(0, 32'h0, 1, 0, 32'h0, 1);
        add(0, 32'h0, 1, 1, 32'h5, 1);
        add(0, 32'h0, 1, 0, 32'h5, 1);
        add(0, 32'h0, 1, 0, 32'h5, 1);
        add(0, 32'h0, 1, 0, 32'h5, 0);
        add(0, 32'h0, 1, 0, 32'h5, 0);
        // Four back-to-back samples: strobes at 2, 5, 8, 11
        add(1, 32'h1, 1, 0, 32'h5, 0);
        add(1, 32'h2, 1, 0, 32'h5, 1);
        add(1, 32'h3, 1, 1, 32'h1, 1);
        add(1, 32'h4, 1, 0, 32'h1, 1);
        add(0, 32'h0, 1, 0, 32'h1, 1);
        add(0, 32'h0, 1, 1, 32'h2, 1);
        add(0, 32'h0, 1, 0, 32'h2, 1);
        add(0, 32'h0, 1, 0, 32'h2, 1);
        add(0, 32'h0, 1, 1, 32'h3, 1);
        add(0, 32'h0, 1, 0, 32'h3, 1);
        add(0, 32'h0, 1, 0, 32'h3, 1);
        add(0, 32'h0, 1, 1, 32'h4, 1);
        add(0, 32'h0, 1, 0, 32'h4, 1);
        add(0, 32'h0, 1, 0, 32'h4, 1);
        add(0, 32'h0, 1, 0, 32'h4, 0);

        RST = 1'b1; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge CLK);
        #1;
        cycle(1, 0, 0);   // reset state, in_ready low during reset

        for (int i = 0; i < tab.size(); i++) begin
            tab_row = tab[i];
            tab_idx = i;
            tab_chk = 1;
            cycle(0, tab[i].vld, tab[i].dat);
        end
        tab_chk = 0;
        chk("count_after_table", issued_count, 16'd5);

        // in_valid held for 10 cycles: 7 accepted, 3 stalled
        n_acc = 0; n_stall = 0;
        for (int i = 0; i < 10; i++) cycle(0, 1, 32'h100 + i);
        chk("hold_accepted", n_acc, 7);
        chk("hold_stalls", n_stall, 3);
        repeat (30) cycle(0, 0, 0);
        chk("hold_issued", issued_count, 16'd12);

        // Reset with samples queued mid-hold
        for (int i = 0; i < 5; i++) cycle(0, 1, 32'hA0 + i);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        RST = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_enable", enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_count", issued_count, 0);
        repeat (12) cycle(0, 0, 0);

        // issued_count wrap
        force dut.issued_count_reg = 16'hFFFF;
        #1;
        release dut.issued_count_reg;
        m_count = 16'hFFFF;
        cycle(0, 1, 32'h7);
        repeat (6) cycle(0, 0, 0);
        chk("count_wrap", issued_count, 16'h0);

        // Downstream accumulator sees each addend held until its add cycle
        acc = '0; acc_pipe = '0;
        cycle(0, 1, 32'h10);
        cycle(0, 1, 32'h20);
        cycle(0, 1, 32'h30);
        repeat (15) cycle(0, 0, 0);
        chk("acc_sum", acc, 32'h60);

        // Randomized traffic with occasional resets
        for (int blk = 0; blk < 4; blk++) begin
            int vprob;
            vprob = (blk == 0) ? 20 : (blk == 1) ? 50 : (blk == 2) ? 90 : 100;
            for (int i = 0; i < 150; i++) begin
                cycle(($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 99) < vprob) ? 1'b1 : 1'b0,
                      $urandom);
            end
        end
        repeat (20) cycle(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/accum_feeder.md
ACCUM_FEEDER -- requirements
Module: accum_feeder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning sample width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries; it must be a power of two, at least 2.
REQ-003 The block SHALL have port CLK  in  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  in  1  upstream sample valid.
REQ-006 The block SHALL have port in_data  in  DATA_W  upstream sample.
REQ-007 The block SHALL have port in_ready  out  1  FIFO can accept a sample this cycle.
REQ-008 The block SHALL have port enable  out  1  one-cycle issue strobe to the downstream accumulator.
REQ-009 The block SHALL have port value  out  DATA_W  addend presented to the downstream accumulator.
REQ-010 The block SHALL have port busy  out  1  high while the FIFO is non-empty or state is not IDLE.
REQ-011 The block SHALL have port issued_count  out  16  number of strobes issued since reset.

Function
REQ-012 A push SHALL occur on each edge where in_valid && in_ready; in_data is written at the tail.
REQ-013 in_ready SHALL be !full && !RST, decoded from registered occupancy; a pop in the same cycle does not enable a push while full.
REQ-014 The FSM SHALL have states IDLE, ISSUE, HOLD1, HOLD2.
REQ-015 In IDLE with FIFO non-empty, the FSM SHALL pop the head into value and go to ISSUE; otherwise it stays in IDLE.
REQ-016 In ISSUE, enable SHALL be 1 for exactly one cycle; the next state is HOLD1.
REQ-017 HOLD1 SHALL go to HOLD2, with enable 0 and value unchanged.
REQ-018 In HOLD2, if the FIFO is non-empty, the FSM SHALL pop into value and go to ISSUE; otherwise it goes to IDLE; enable is 0.
REQ-019 value SHALL be stable from the ISSUE cycle through the following two cycles (the downstream add occurs 2 cycles after enable).
REQ-020 Back-to-back enable strobes SHALL be exactly 3 cycles apart minimum, never closer.
REQ-021 Latency SHALL be 2 cycles: a push into an empty FIFO while IDLE at cycle 0 gives enable=1 at cycle 2.
REQ-022 Push and pop in the same cycle SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-023 Pops SHALL occur only in IDLE or HOLD2 with FIFO non-empty; no pop ever occurs when empty.
REQ-024 Samples SHALL be issued in arrival order, none dropped or duplicated.
REQ-025 issued_count SHALL increment by 1 on each ISSUE cycle and wrap from 0xFFFF to 0.
REQ-026 value SHALL retain the last issued sample in IDLE.

Reset
REQ-027 While RST is high at an edge, the block SHALL set state to IDLE, enable=0, value=0, issued_count=0, FIFO empty (pointers 0), busy=0.
REQ-028 Reset mid-operation, including during ISSUE/HOLD with a full FIFO, SHALL discard all queued samples; enable is 0 from the cycle after the reset edge.
REQ-029 in_ready SHALL be 0 while RST is high and 1 in the first cycle after release.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (2-bit) and the DEPTH/DATA_W default constants.
REQ-031 The FIFO SHALL be one sub-module, feeder_fifo (parameterised DATA_W/DEPTH, push/pop/full/empty/head), instantiated once; the FSM and counter live in accum_feeder.

Verification
REQ-032 Single sample 0x0000_0005 pushed at cycle 0 after reset SHALL give enable=1 at cycle 2 only, value=5 for cycles 2-4, issued_count=1.
REQ-033 Pushing 4 samples 1,2,3,4 on consecutive cycles with DEPTH=4 SHALL give enable at cycles 2,5,8,11, values in order, and in_ready never low.
REQ-034 Holding in_valid high for 10 cycles SHALL drop in_ready when occupancy reaches 4, accept exactly the samples for which ready was high, and issue all of them in order.
REQ-035 Asserting RST at cycle 6 with 3 samples queued SHALL give enable=0 and busy=0 from cycle 7, and no stale sample is issued after release.
REQ-036 With issued_count preloaded by 65535 issues, one more sample SHALL make issued_count read 0.
REQ-037 A bench model of the downstream 3-state accumulator fed 0x10, 0x20, 0x30 SHALL end with its sum 0x60, proving the hold timing.
